// File: rtl/grid_row_editor_if.sv
// Bus bundle for the LED-matrix row editor: button/edit inputs toward the
// editor, stored grid, cursor and write acknowledge back to the front end.
//
// Handshake: there is no valid/ready pair. A write request is the rising
// edge of Set (sampled with Pause=1, Clear=0). The editor answers each
// accepted request with a single-cycle wrote pulse in the cycle after the
// accepting edge. Set must drop for at least one cycle before the next
// request can be taken.
interface grid_row_editor_if #(
   parameter int ROWS = 8,
   parameter int COLS = 8
);
   localparam int CUR_W = $clog2(ROWS);

   logic                      Pause;
   logic                      Set;
   logic                      Clear;
   logic                      up;
   logic                      down;
   logic [1:0]                mode;
   logic [COLS-1:0]           thisRow;
   logic [ROWS-1:0][COLS-1:0] lights;
   logic [CUR_W-1:0]          cursor;
   logic                      wrote;
   // auto-repeat state machine, visible for debug
   logic [1:0]                rpt_state;

   modport master (
      output Pause, Set, Clear, up, down, mode, thisRow,
      input  lights, cursor, wrote, rpt_state
   );

   modport slave (
      input  Pause, Set, Clear, up, down, mode, thisRow,
      output lights, cursor, wrote, rpt_state
   );
endinterface

// File: rtl/grid_row_editor.sv
// Row editor for the LED matrix: cursor with optional wrap and hold-to-repeat,
// edge-qualified row writes with four combine modes, global clear and an
// optional clear-while-running behaviour. All outputs are registered.
module grid_row_editor #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int WRAP         = 0,
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_RATE  = 1,
   parameter int CLEAR_ON_RUN = 1
) (
   input logic              Clock,
   input logic              Reset,
   grid_row_editor_if.slave bus
);

   localparam int CUR_W   = $clog2(ROWS);
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CUR_W-1:0] LAST_ROW  = CUR_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      RPT_IDLE  = 2'd0,
      RPT_DELAY = 2'd1,
      RPT_RATE  = 2'd2
   } rpt_state_t;

   // edge-detect registers (reset to 1 so a button held through reset is ignored)
   logic prev_up_q, prev_up_d;
   logic prev_down_q, prev_down_d;
   logic prev_set_q, prev_set_d;

   // auto-repeat state
   rpt_state_t       rpt_state_q, rpt_state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             hold_dn_q, hold_dn_d;

   // cursor and grid state
   logic [CUR_W-1:0]          cursor_q, cursor_d;
   logic [ROWS-1:0][COLS-1:0] grid_q, grid_d;
   logic                      wrote_q, wrote_d;

   // combinational helpers
   logic             up_rise, down_rise, set_rise;
   logic             step_up, step_dn;
   logic             held_same;
   logic [CNT_W-1:0] hold_inc;
   logic [COLS-1:0]  cur_row, new_row;
   logic             do_write;

   // Rising-edge detection on the three buttons
   always_comb begin
      prev_up_d   = bus.up;
      prev_down_d = bus.down;
      prev_set_d  = bus.Set;
      up_rise     = bus.up & ~prev_up_q;
      down_rise   = bus.down & ~prev_down_q;
      set_rise    = bus.Set & ~prev_set_q;
   end

   // Edge-detect registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         prev_up_q   <= 1'b1;
         prev_down_q <= 1'b1;
         prev_set_q  <= 1'b1;
      end else begin
         prev_up_q   <= prev_up_d;
         prev_down_q <= prev_down_d;
         prev_set_q  <= prev_set_d;
      end
   end

   // Auto-repeat next state: the counter holds the number of edges since the
   // last step, so a step fires when it reaches the delay (first) or rate (rest)
   always_comb begin
      rpt_state_d = rpt_state_q;
      hold_cnt_d  = hold_cnt_q;
      hold_dn_d   = hold_dn_q;
      step_up     = 1'b0;
      step_dn     = 1'b0;
      held_same   = (rpt_state_q != RPT_IDLE) && (hold_dn_q ? bus.down : bus.up);
      hold_inc    = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_ONE;

      if (bus.up && bus.down) begin
         rpt_state_d = RPT_IDLE;
         hold_cnt_d  = '0;
      end else if (up_rise || down_rise) begin
         step_up   = up_rise;
         step_dn   = down_rise;
         hold_dn_d = down_rise;
         if (REPEAT_DELAY > 0) begin
            rpt_state_d = RPT_DELAY;
            hold_cnt_d  = CNT_ONE;
         end else begin
            rpt_state_d = RPT_IDLE;
            hold_cnt_d  = '0;
         end
      end else if (held_same) begin
         hold_cnt_d = hold_inc;
         case (rpt_state_q)
            RPT_DELAY: begin
               if (hold_cnt_q == DELAY_CNT) begin
                  step_up     = ~hold_dn_q;
                  step_dn     = hold_dn_q;
                  rpt_state_d = RPT_RATE;
                  hold_cnt_d  = CNT_ONE;
               end
            end
            RPT_RATE: begin
               if (hold_cnt_q == RATE_CNT) begin
                  step_up    = ~hold_dn_q;
                  step_dn    = hold_dn_q;
                  hold_cnt_d = CNT_ONE;
               end
            end
            default: begin
               rpt_state_d = RPT_IDLE;
               hold_cnt_d  = '0;
            end
         endcase
      end else begin
         rpt_state_d = RPT_IDLE;
         hold_cnt_d  = '0;
      end
   end

   // Auto-repeat state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rpt_state_q <= RPT_IDLE;
         hold_cnt_q  <= '0;
         hold_dn_q   <= 1'b0;
      end else begin
         rpt_state_q <= rpt_state_d;
         hold_cnt_q  <= hold_cnt_d;
         hold_dn_q   <= hold_dn_d;
      end
   end

   // Cursor next value: wrap or saturate at both ends
   always_comb begin
      cursor_d = cursor_q;
      if (step_up) begin
         if (cursor_q == '0) begin
            cursor_d = (WRAP != 0) ? LAST_ROW : '0;
         end else begin
            cursor_d = cursor_q - CUR_W'(1);
         end
      end else if (step_dn) begin
         if (cursor_q == LAST_ROW) begin
            cursor_d = (WRAP != 0) ? '0 : LAST_ROW;
         end else begin
            cursor_d = cursor_q + CUR_W'(1);
         end
      end
   end

   // Cursor register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cursor_q <= '0;
      end else begin
         cursor_q <= cursor_d;
      end
   end

   // Grid next value: clear beats write; the target row is the pre-edge cursor
   always_comb begin
      grid_d   = grid_q;
      wrote_d  = 1'b0;
      cur_row  = grid_q[cursor_q];
      do_write = set_rise & bus.Pause & ~bus.Clear;
      case (bus.mode)
         2'b00:   new_row = bus.thisRow;
         2'b01:   new_row = cur_row | bus.thisRow;
         2'b10:   new_row = cur_row & ~bus.thisRow;
         default: new_row = cur_row ^ bus.thisRow;
      endcase

      if (bus.Clear || (!bus.Pause && (CLEAR_ON_RUN != 0))) begin
         grid_d = '0;
      end else if (do_write) begin
         grid_d[cursor_q] = new_row;
         wrote_d          = 1'b1;
      end
   end

   // Grid and write-acknowledge registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         grid_q  <= '0;
         wrote_q <= 1'b0;
      end else begin
         grid_q  <= grid_d;
         wrote_q <= wrote_d;
      end
   end

   assign bus.lights    = grid_q;
   assign bus.cursor    = cursor_q;
   assign bus.wrote     = wrote_q;
   assign bus.rpt_state = rpt_state_q;

endmodule

// File: tb/tb_grid_row_editor.sv
// Bench for grid_row_editor: two instances, one saturating / clear-on-run /
// no repeat, one wrapping / retain-on-run / repeat delay 4 rate 2.
module tb_grid_row_editor;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef struct packed {
      logic       p;
      logic       u;
      logic       d;
      logic       s;
      logic       c;
      logic [1:0] m;
      logic [7:0] r;
      logic [2:0] ecur;
      logic [2:0] eidx;
      logic [7:0] erow;
      logic       ewr;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   grid_row_editor_if #(.ROWS(ROWS), .COLS(COLS)) bus0 ();
   grid_row_editor_if #(.ROWS(ROWS), .COLS(COLS)) bus1 ();

   grid_row_editor #(
      .ROWS(ROWS), .COLS(COLS), .WRAP(0), .REPEAT_DELAY(0),
      .REPEAT_RATE(1), .CLEAR_ON_RUN(1)
   ) dut0 (
      .Clock(clk), .Reset(rst), .bus(bus0)
   );

   grid_row_editor #(
      .ROWS(ROWS), .COLS(COLS), .WRAP(1), .REPEAT_DELAY(4),
      .REPEAT_RATE(2), .CLEAR_ON_RUN(0)
   ) dut1 (
      .Clock(clk), .Reset(rst), .bus(bus1)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [11:0] exp_q[$];
   vec_t        vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic p, u, d, s, c, input logic [1:0] m, input logic [7:0] r);
      bus0.Pause = p; bus0.up = u; bus0.down = d; bus0.Set = s;
      bus0.Clear = c; bus0.mode = m; bus0.thisRow = r;
   endtask

   task automatic drive1(input logic p, u, d, s, c, input logic [1:0] m, input logic [7:0] r);
      bus1.Pause = p; bus1.up = u; bus1.down = d; bus1.Set = s;
      bus1.Clear = c; bus1.mode = m; bus1.thisRow = r;
   endtask

   function automatic vec_t mk(input logic p, u, d, s, c, input logic [1:0] m,
                               input logic [7:0] r, input logic [2:0] ecur, eidx,
                               input logic [7:0] erow, input logic ewr);
      vec_t v;
      v = {p, u, d, s, c, m, r, ecur, eidx, erow, ewr};
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [11:0] exp_w;
      logic [2:0]  rpt_exp[10];
      vec_t        v;

      drive0(0, 1, 0, 0, 0, 2'd0, 8'h00);
      drive1(0, 0, 0, 0, 0, 2'd0, 8'h00);

      // Vector table for dut0, starting at cursor 3 with an empty grid
      vecs.push_back(mk(1,1,0,0,0,2'd0,8'h00, 3'd2,3'd2,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,1,0,2'd0,8'hF0, 3'd2,3'd2,8'hF0,1'b1));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd2,3'd2,8'hF0,1'b0));
      vecs.push_back(mk(1,0,0,1,0,2'd1,8'h0F, 3'd2,3'd2,8'hFF,1'b1));
      vecs.push_back(mk(1,0,0,0,0,2'd1,8'h0F, 3'd2,3'd2,8'hFF,1'b0));
      vecs.push_back(mk(1,0,0,1,0,2'd2,8'h3C, 3'd2,3'd2,8'hC3,1'b1));
      vecs.push_back(mk(1,0,0,0,0,2'd2,8'h3C, 3'd2,3'd2,8'hC3,1'b0));
      vecs.push_back(mk(1,0,0,1,0,2'd3,8'hFF, 3'd2,3'd2,8'h3C,1'b1));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1,0,0,1,0,2'd3,8'hFF, 3'd2,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd2,3'd2,8'h3C,1'b0));
      // saturating boundary at row 0
      vecs.push_back(mk(1,1,0,0,0,2'd0,8'h00, 3'd1,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd1,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,1,0,0,0,2'd0,8'h00, 3'd0,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd0,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,1,0,0,0,2'd0,8'h00, 3'd0,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd0,3'd2,8'h3C,1'b0));
      // both buttons rising together
      vecs.push_back(mk(1,1,1,0,0,2'd0,8'h00, 3'd0,3'd2,8'h3C,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd0,3'd2,8'h3C,1'b0));
      // walk down to row 4
      for (int i = 1; i <= 4; i++) begin
         vecs.push_back(mk(1,0,1,0,0,2'd0,8'h00, 3'(i),3'd2,8'h3C,1'b0));
         vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'(i),3'd2,8'h3C,1'b0));
      end
      // write and move at the same edge, then clear against a Set edge
      vecs.push_back(mk(1,0,1,1,0,2'd0,8'hA5, 3'd5,3'd4,8'hA5,1'b1));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd5,3'd4,8'hA5,1'b0));
      vecs.push_back(mk(1,0,0,1,1,2'd0,8'h55, 3'd5,3'd4,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd5,3'd2,8'h00,1'b0));
      // saturating boundary at row 7
      vecs.push_back(mk(1,0,1,0,0,2'd0,8'h00, 3'd6,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd6,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,1,0,0,2'd0,8'h00, 3'd7,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd7,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,1,0,0,2'd0,8'h00, 3'd7,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd7,3'd7,8'h00,1'b0));
      // run mode clears, Set while running is dropped
      vecs.push_back(mk(1,0,0,1,0,2'd0,8'h81, 3'd7,3'd7,8'h81,1'b1));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd7,3'd7,8'h81,1'b0));
      vecs.push_back(mk(0,0,0,0,0,2'd0,8'h00, 3'd7,3'd7,8'h00,1'b0));
      vecs.push_back(mk(0,0,0,1,0,2'd0,8'hFF, 3'd7,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,1,0,2'd0,8'hFF, 3'd7,3'd7,8'h00,1'b0));
      vecs.push_back(mk(1,0,0,0,0,2'd0,8'h00, 3'd7,3'd7,8'h00,1'b0));

      // ---- reset with up held ----
      repeat (3) @(posedge clk);
      #1;
      check("rst_cursor0", 64'(bus0.cursor), 64'd0);
      check("rst_lights0", bus0.lights, 64'd0);
      check("rst_wrote0", 64'(bus0.wrote), 64'd0);
      rst = 1'b0;
      repeat (3) tick();
      check("held_up_no_move", 64'(bus0.cursor), 64'd0);
      check("rst_cursor1", 64'(bus1.cursor), 64'd0);
      bus0.up = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus0.down = 1'b1; tick();
         bus0.down = 1'b0; tick();
      end
      check("three_downs", 64'(bus0.cursor), 64'd3);

      // ---- table-driven vectors on dut0 ----
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive0(v.p, v.u, v.d, v.s, v.c, v.m, v.r);
         exp_q.push_back({v.ecur, v.erow, v.ewr});
         tick();
         exp_w = exp_q.pop_front();
         check($sformatf("vec%0d {cursor,row,wrote}", i),
               64'({bus0.cursor, bus0.lights[v.eidx], bus0.wrote}), 64'(exp_w));
      end
      check("grid_after_run", bus0.lights, 64'd0);

      // ---- dut1: wrap, retain-on-run ----
      drive1(1, 0, 0, 1, 0, 2'd0, 8'h5A); tick();
      check("d1_write_wrote", 64'(bus1.wrote), 64'd1);
      check("d1_write_row0", 64'(bus1.lights[0]), 64'h5A);
      drive1(1, 0, 0, 0, 0, 2'd0, 8'h00); tick();
      check("d1_wrote_drop", 64'(bus1.wrote), 64'd0);
      drive1(1, 1, 0, 0, 0, 2'd0, 8'h00); tick();
      check("d1_wrap_up", 64'(bus1.cursor), 64'd7);
      drive1(1, 0, 0, 0, 0, 2'd0, 8'h00); tick();
      drive1(1, 0, 1, 0, 0, 2'd0, 8'h00); tick();
      check("d1_wrap_down", 64'(bus1.cursor), 64'd0);
      drive1(1, 0, 0, 0, 0, 2'd0, 8'h00); tick();
      drive1(0, 0, 0, 0, 0, 2'd0, 8'h00); tick(); tick();
      check("d1_retain_on_run", bus1.lights, 64'h5A);
      drive1(0, 0, 0, 1, 0, 2'd0, 8'hFF); tick();
      drive1(1, 0, 0, 1, 0, 2'd0, 8'hFF); tick();
      check("d1_no_replay_wrote", 64'(bus1.wrote), 64'd0);
      drive1(1, 0, 0, 0, 0, 2'd0, 8'h00); tick();
      check("d1_no_replay_grid", bus1.lights, 64'h5A);

      // ---- dut1: auto-repeat, steps at edges 0,4,6,8 ----
      rpt_exp = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
      drive1(1, 0, 1, 0, 0, 2'd0, 8'h00);
      for (int e = 0; e < 10; e++) begin
         exp_q.push_back({rpt_exp[e], 8'h00, 1'b0});
         tick();
         exp_w = exp_q.pop_front();
         check($sformatf("repeat_edge%0d cursor", e), 64'(bus1.cursor), 64'(exp_w[11:9]));
      end

      // asynchronous reset mid-hold
      rst = 1'b1;
      #2;
      check("d1_async_rst_cursor", 64'(bus1.cursor), 64'd0);
      check("d1_async_rst_grid", bus1.lights, 64'd0);
      check("d0_async_rst_cursor", 64'(bus0.cursor), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      check("d1_hold_after_rst", 64'(bus1.cursor), 64'd0);

      // ---- dut0: in-flight wrote cancelled by reset ----
      drive0(1, 0, 0, 0, 0, 2'd0, 8'h00); tick();
      drive0(1, 0, 0, 1, 0, 2'd0, 8'h77); tick();
      check("d0_wrote_before_rst", 64'(bus0.wrote), 64'd1);
      check("d0_row0_before_rst", bus0.lights, 64'h77);
      rst = 1'b1;
      #2;
      check("d0_wrote_cancelled", 64'(bus0.wrote), 64'd0);
      check("d0_grid_cleared", bus0.lights, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // ---- report ----
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/grid_row_editor.md
# grid_row_editor

Parametrised row editor for the LED-matrix front end of the solver board: a cursor steps over `ROWS` rows via up/down buttons, with optional wrap and hold-to-repeat. While the design is paused, each Set press commits a `COLS`-bit input pattern into the row under the cursor using one of four combine modes. The stored grid drives the display directly. It supersedes the fixed 8×8 editor and adds the following:
- edge-qualified writes
- combine modes
- a global clear
- a retain-on-run option

## Interface
Parameters:
- `ROWS`, 8: number of grid rows; must be ≥2.
- `COLS`, 8: bits per row.
- `WRAP`, 0: 1 means the cursor wraps at both ends; 0 means it saturates.
- `REPEAT_DELAY`, 0: held-button cycles before the first auto-repeat step; 0 disables auto-repeat.
- `REPEAT_RATE`, 1: cycles between auto-repeat steps after the first; must be ≥1.
- `CLEAR_ON_RUN`, 1: 1 means the grid is forced to 0 whenever `Pause`=0 (legacy behaviour); 0 means the grid is retained.

Ports:
- `Clock`, input, 1: the single clock. All state changes on its rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Pause`, input, 1: edit enable. Writes are accepted only while it is high.
- `Set`, input, 1: write request. It is rising-edge qualified.
- `Clear`, input, 1: level signal that zeroes the entire grid.
- `up`, input, 1: moves the cursor toward row 0. It is rising-edge qualified and supports auto-repeat.
- `down`, input, 1: moves the cursor toward row `ROWS`-1. It is rising-edge qualified and supports auto-repeat.
- `mode`, input, 2: combine operation for a write. 00 load, 01 OR, 10 AND-NOT (clear the set bits), 11 XOR.
- `thisRow`, input, `COLS`: pattern to write.
- `lights`, output, `ROWS`×`COLS`: the stored grid. It is a packed array and `lights[r]` is row r.
- `cursor`, output, `$clog2(ROWS)`: current row index.
- `wrote`, output, 1: one-cycle pulse acknowledging a committed write.

## Operation
Inputs:
- All inputs are synchronous to `Clock`. Synchronisation and debouncing happen upstream.
- `prev_up`, `prev_down` and `prev_set` register the inputs for edge detection.
- These edge-detect registers reset to 1. A button held through reset therefore produces no action until it is released and pressed again.

Cursor:
- Rising edge of `up` with `down` low: the cursor decrements.
  - At row 0 it goes to `ROWS`-1 if `WRAP`=1, otherwise it stays at 0.
- Rising edge of `down` with `up` low: the cursor increments.
  - At `ROWS`-1 it goes to 0 if `WRAP`=1, otherwise it stays at `ROWS`-1.
- `up` and `down` both high: no move, and the hold counter clears.
- The cursor moves regardless of `Pause`.

Auto-repeat:
- Applies when `REPEAT_DELAY`>0.
- Assume the edge step is taken at clock edge k and the same single button stays high. Further steps then occur at edges k+`REPEAT_DELAY`, then every `REPEAT_RATE` edges after that.
- Releasing the button, or pressing both buttons, clears the counter.
- The hold counter saturates and does not wrap.

Write:
- A write occurs at edge k when `Set` is 1 and `prev_set` is 0, with `Pause`=1 and `Clear`=0.
- It updates `grid[c]`, where c is the cursor value before edge k. A cursor move at that same edge does not affect the target row.
- New row value by mode:
  - load: `thisRow`
  - OR: `grid[c]` | `thisRow`
  - AND-NOT: `grid[c]` & ~`thisRow`
  - XOR: `grid[c]` ^ `thisRow`
- `wrote`=1 for exactly the cycle after edge k.
- Holding `Set` does not cause further writes.

Clear and run behaviour:
- `Clear`=1 at an edge zeroes all rows. It takes priority over a write, and `wrote` stays 0.
- `Pause`=0 with `CLEAR_ON_RUN`=1 zeroes all rows at each edge.
- `Pause`=0 with `CLEAR_ON_RUN`=0 holds the grid.
- A `Set` edge while `Pause`=0 is consumed: `prev_set` updates, and the press is not remembered for later.

## Timing
- Reset values:
  - `lights`=0, `cursor`=0, `wrote`=0.
  - Hold counter 0.
  - `prev_up`, `prev_down`, `prev_set` = 1.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge. An in-flight `wrote` pulse is cancelled.
- Cursor latency: 1 edge from a button rising edge to the new `cursor` value.
- Write latency: 1 edge from a `Set` edge to the updated `lights[c]` and `wrote`=1; both become visible together.
- Clear latency: 1 edge.
- Back-to-back writes: the minimum spacing is 2 cycles, because `Set` must drop for one cycle between presses.
- Output timing: all outputs are registered, with no combinational path from input to output.

## Test plan
1. Reset sequence:
   - Assert `Reset` with `up` held.
   - Release `Reset`. `cursor` must be 0 and `lights` must be 0.
   - `up` still held produces no move.
   - Release `up`, then pulse `down` three times. `cursor` must be 3.
2. Boundary behaviour at `ROWS`=8:
   - `WRAP`=0: `up` at row 0 leaves the cursor at 0; `down` at row 7 leaves it at 7.
   - `WRAP`=1: `up` at row 0 gives 7; `down` at row 7 gives 0.
   - `up` and `down` rising together gives no move.
3. Write modes at cursor 2 with `Pause`=1:
   - load `thisRow`=8'hF0 gives `lights[2]`=F0 and a single `wrote` pulse.
   - OR 8'h0F gives FF.
   - AND-NOT 8'h3C gives C3.
   - XOR 8'hFF gives 3C.
   - Holding `Set` for 5 cycles produces one write only.
4. Same-edge write and move:
   - `Set` edge and `down` edge at the same edge with cursor 4.
   - Row 4 is written and `cursor` becomes 5.
   - `Clear` held with a `Set` edge gives an all-zero grid and `wrote`=0.
5. Run mode with rows written:
   - `Pause`→0 with `CLEAR_ON_RUN`=1 gives `lights`=0 after one edge.
   - `Pause`→0 with `CLEAR_ON_RUN`=0 leaves the grid unchanged.
   - A `Set` edge while `Pause`=0 is ignored and is not replayed when `Pause` returns to 1.
6. Auto-repeat with `REPEAT_DELAY`=4 and `REPEAT_RATE`=2:
   - Hold `down` from cursor 0 for 10 edges. The cursor steps at edges 0, 4, 6, 8, giving a final value of 4.
   - Assert `Reset` mid-hold: the cursor returns to 0 immediately.
